// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: ALU op encoding, opcode and funct constants.
// The execute-stage ALU imports aluop_e from here so both sides agree on encoding.
package decode_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SRL  = 4'd3,
        ALU_SRA  = 4'd4,
        ALU_AND  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_XOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        aluop_e     aluop;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       src1_pc;
        logic       src2_imm;
        logic       reg_write;
        logic       branch;
        logic [2:0] funct3;
        logic       illegal;
    } ctrl_t;

    // alt selects SUB/SRA; the caller decides whether the alternate form is legal.
    function automatic aluop_e funct3_to_aluop(input logic [2:0] funct3, input logic alt);
        aluop_e op;
        op = ALU_ADD;
        case (funct3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            F3_AND:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate extraction for every instruction format.
// All immediates sign-extend from bit 31 except the shift amount.
module imm_gen
    import decode_pkg::*;
(
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] imm_s,
    output logic [XLEN-1:0] imm_b,
    output logic [XLEN-1:0] imm_u,
    output logic [XLEN-1:0] imm_j,
    output logic [XLEN-1:0] imm_shamt
);

    assign imm_i     = {{20{instr[31]}}, instr[31:20]};
    assign imm_s     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u     = {instr[31:12], 12'h000};
    assign imm_j     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_shamt = {27'd0, instr[24:20]};

endmodule

// File: rtl/decode_stage.sv
// RV32I decode pipeline stage: combinational decode ahead of one output register
// bank with valid/ready handshakes on both sides and a synchronous flush.
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [DATA_WIDTH-1:0] in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [3:0]            out_aluop,
    output logic [4:0]            out_rs1,
    output logic [4:0]            out_rs2,
    output logic [4:0]            out_rd,
    output logic [DATA_WIDTH-1:0] out_imm,
    output logic                  out_src1_pc,
    output logic                  out_src2_imm,
    output logic                  out_reg_write,
    output logic                  out_branch,
    output logic [2:0]            out_funct3,
    output logic                  out_illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_shamt;

    ctrl_t                 ctrl_d, ctrl_q;
    logic [DATA_WIDTH-1:0] imm_d, imm_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic                  valid_q;
    logic                  in_fire;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    imm_gen u_imm_gen (
        .instr     (in_instr),
        .imm_i     (imm_i),
        .imm_s     (imm_s),
        .imm_b     (imm_b),
        .imm_u     (imm_u),
        .imm_j     (imm_j),
        .imm_shamt (imm_shamt)
    );

    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves one unassigned (no latches).
        ctrl_d           = '0;
        ctrl_d.aluop     = ALU_ADD;
        ctrl_d.rs1       = in_instr[19:15];
        ctrl_d.rs2       = in_instr[24:20];
        ctrl_d.rd        = in_instr[11:7];
        ctrl_d.funct3    = funct3;
        ctrl_d.reg_write = 1'b1;
        imm_d            = '0;

        case (opcode)
            OPC_OP: begin
                ctrl_d.aluop   = funct3_to_aluop(funct3, funct7 == F7_ALT);
                ctrl_d.illegal = !((funct7 == F7_BASE) ||
                                   (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR)));
            end
            OPC_OP_IMM: begin
                ctrl_d.src2_imm = 1'b1;
                if (funct3 == F3_SLL || funct3 == F3_SR) begin
                    imm_d          = imm_shamt;
                    ctrl_d.aluop   = funct3_to_aluop(funct3, funct7 == F7_ALT);
                    ctrl_d.illegal = !((funct7 == F7_BASE) ||
                                       (funct7 == F7_ALT && funct3 == F3_SR));
                end else begin
                    imm_d        = imm_i;
                    ctrl_d.aluop = funct3_to_aluop(funct3, 1'b0);
                end
            end
            OPC_LUI: begin
                ctrl_d.rs1      = '0;
                ctrl_d.src2_imm = 1'b1;
                imm_d           = imm_u;
            end
            OPC_AUIPC: begin
                ctrl_d.src1_pc  = 1'b1;
                ctrl_d.src2_imm = 1'b1;
                imm_d           = imm_u;
            end
            OPC_LOAD: begin
                ctrl_d.src2_imm = 1'b1;
                imm_d           = imm_i;
            end
            OPC_STORE: begin
                ctrl_d.src2_imm  = 1'b1;
                ctrl_d.reg_write = 1'b0;
                imm_d            = imm_s;
            end
            OPC_BRANCH: begin
                ctrl_d.branch    = 1'b1;
                ctrl_d.reg_write = 1'b0;
                imm_d            = imm_b;
                case (funct3)
                    F3_BEQ, F3_BNE:   ctrl_d.aluop = ALU_SUB;
                    F3_BLT, F3_BGE:   ctrl_d.aluop = ALU_SLT;
                    F3_BLTU, F3_BGEU: ctrl_d.aluop = ALU_SLTU;
                    default:          ctrl_d.illegal = 1'b1;
                endcase
            end
            OPC_JAL: begin
                ctrl_d.src1_pc  = 1'b1;
                ctrl_d.src2_imm = 1'b1;
                imm_d           = imm_j;
            end
            OPC_JALR: begin
                ctrl_d.src2_imm = 1'b1;
                imm_d           = imm_i;
            end
            default: ctrl_d.illegal = 1'b1;
        endcase

        // Illegal bundles still flow so execute can trap, but must not have side effects.
        if (ctrl_d.illegal) begin
            ctrl_d.aluop     = ALU_ADD;
            ctrl_d.reg_write = 1'b0;
            ctrl_d.branch    = 1'b0;
            ctrl_d.src1_pc   = 1'b0;
            ctrl_d.src2_imm  = 1'b0;
            imm_d            = '0;
        end
        if (ctrl_d.rd == 5'd0) ctrl_d.reg_write = 1'b0;
    end

    assign in_ready = !rst && (!valid_q || out_ready);
    assign in_fire  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            imm_q   <= '0;
            ctrl_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (in_fire) begin
            valid_q <= 1'b1;
            pc_q    <= in_pc;
            imm_q   <= imm_d;
            ctrl_q  <= ctrl_d;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid     = valid_q;
    assign out_pc        = pc_q;
    assign out_imm       = imm_q;
    assign out_aluop     = ctrl_q.aluop;
    assign out_rs1       = ctrl_q.rs1;
    assign out_rs2       = ctrl_q.rs2;
    assign out_rd        = ctrl_q.rd;
    assign out_src1_pc   = ctrl_q.src1_pc;
    assign out_src2_imm  = ctrl_q.src2_imm;
    assign out_reg_write = ctrl_q.reg_write;
    assign out_branch    = ctrl_q.branch;
    assign out_funct3    = ctrl_q.funct3;
    assign out_illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: instruction-level reference model compared
// every cycle, plus hand-computed expectations for the directed vectors.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc, out_imm;
    logic [3:0]  out_aluop;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic        out_src1_pc, out_src2_imm, out_reg_write, out_branch, out_illegal;
    logic [2:0]  out_funct3;

    always #5 clk = ~clk;

    decode_stage #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_aluop(out_aluop), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_imm(out_imm), .out_src1_pc(out_src1_pc), .out_src2_imm(out_src2_imm),
        .out_reg_write(out_reg_write), .out_branch(out_branch),
        .out_funct3(out_funct3), .out_illegal(out_illegal)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  aluop;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic        src1_pc, src2_imm, reg_write, branch;
        logic [2:0]  funct3;
        logic        illegal;
    } exp_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decoder written from the ISA tables, independent of the RTL structure.
    function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
        exp_t        e;
        logic [3:0]  f3_op [8];
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
        bit          ill, shift;
        f3_op = '{4'd0, 4'd2, 4'd8, 4'd9, 4'd7, 4'd3, 4'd6, 4'd5};
        f3    = i[14:12];
        f7    = i[31:25];
        imm_i = 32'($signed(i[31:20]));
        imm_s = 32'($signed({i[31:25], i[11:7]}));
        imm_b = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
        imm_u = {i[31:12], 12'h000};
        imm_j = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
        e = '0;
        e.pc = pc; e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7];
        e.funct3 = f3; e.reg_write = 1'b1;
        ill = 1'b0;
        case (i[6:0])
            7'h33: begin
                e.aluop = f3_op[f3];
                if (f7 == 7'h20 && f3 == 3'd0)      e.aluop = 4'd1;
                else if (f7 == 7'h20 && f3 == 3'd5) e.aluop = 4'd4;
                else if (f7 != 7'h00)               ill = 1'b1;
            end
            7'h13: begin
                e.aluop = f3_op[f3];
                e.src2_imm = 1'b1;
                shift = (f3 == 3'd1) || (f3 == 3'd5);
                e.imm = shift ? {27'd0, i[24:20]} : imm_i;
                if (shift) begin
                    if (f3 == 3'd5 && f7 == 7'h20) e.aluop = 4'd4;
                    else if (f7 != 7'h00)          ill = 1'b1;
                end
            end
            7'h37: begin e.rs1 = 5'd0; e.src2_imm = 1'b1; e.imm = imm_u; end
            7'h17: begin e.src1_pc = 1'b1; e.src2_imm = 1'b1; e.imm = imm_u; end
            7'h03: begin e.src2_imm = 1'b1; e.imm = imm_i; end
            7'h23: begin e.src2_imm = 1'b1; e.imm = imm_s; e.reg_write = 1'b0; end
            7'h63: begin
                e.branch = 1'b1; e.reg_write = 1'b0; e.imm = imm_b;
                if (f3 == 3'd2 || f3 == 3'd3) ill = 1'b1;
                else e.aluop = (f3 < 3'd4) ? 4'd1 : ((f3 < 3'd6) ? 4'd8 : 4'd9);
            end
            7'h6F: begin e.src1_pc = 1'b1; e.src2_imm = 1'b1; e.imm = imm_j; end
            7'h67: begin e.src2_imm = 1'b1; e.imm = imm_i; end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            e.illegal = 1'b1; e.aluop = 4'd0; e.reg_write = 1'b0; e.branch = 1'b0;
            e.src1_pc = 1'b0; e.src2_imm = 1'b0; e.imm = '0;
        end
        if (e.rd == 5'd0) e.reg_write = 1'b0;
        return e;
    endfunction

    // Stage occupancy model: what the output register must hold after each edge.
    exp_t          m_b;
    bit            m_live = 1'b0, m_valid = 1'b0, m_zero = 1'b1;
    logic [31:0]   delivered [$];

    always @(posedge clk) begin
        bit drained, accepted;
        if (rst) begin
            m_live = 1'b1; m_valid = 1'b0; m_zero = 1'b1; m_b = '0;
        end else if (m_live) begin
            drained  = m_valid && out_ready;
            accepted = in_valid && (!m_valid || out_ready);
            if (accepted && !flush) begin
                m_b    = model(in_instr, in_pc);
                m_zero = 1'b0;
            end
            m_valid = !flush && (accepted || (m_valid && !drained));
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("in_ready", 32'(in_ready), 32'(!rst && (!m_valid || out_ready)));
            check("out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid || m_zero) begin
                check("out_pc", out_pc, m_b.pc);
                check("out_aluop", 32'(out_aluop), 32'(m_b.aluop));
                check("out_rs1", 32'(out_rs1), 32'(m_b.rs1));
                check("out_rs2", 32'(out_rs2), 32'(m_b.rs2));
                check("out_rd", 32'(out_rd), 32'(m_b.rd));
                check("out_imm", out_imm, m_b.imm);
                check("out_src1_pc", 32'(out_src1_pc), 32'(m_b.src1_pc));
                check("out_src2_imm", 32'(out_src2_imm), 32'(m_b.src2_imm));
                check("out_reg_write", 32'(out_reg_write), 32'(m_b.reg_write));
                check("out_branch", 32'(out_branch), 32'(m_b.branch));
                check("out_funct3", 32'(out_funct3), 32'(m_b.funct3));
                check("out_illegal", 32'(out_illegal), 32'(m_b.illegal));
            end
            if (out_valid && out_ready) delivered.push_back(out_pc);
        end
    end

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SRAI = 32'h40335293;
    localparam logic [31:0] I_BLT  = 32'hFE20CCE3;
    localparam logic [31:0] I_SUB  = 32'h403100B3;
    localparam logic [31:0] I_ILL  = 32'hFFFFFFFF;

    logic [31:0] stream [18] = '{
        32'h403100B3, 32'h00509093, 32'hFFF1B113, 32'h123453B7, 32'h00001417,
        32'hFFC12483, 32'h00512423, 32'h010000EF, 32'h00008067, 32'h0020F463,
        32'h022081B3, 32'h40509093, 32'h0020A463, 32'h0000000F, 32'h40310033,
        32'h4030D0B3, 32'h7FF24213, 32'h403110B3
    };

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    initial begin
        exp_t pin;
        int   hits;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;

        pin = model(I_SRAI, 32'h0);
        check("model_srai_imm", pin.imm, 32'h00000003);
        pin = model(I_BLT, 32'h0);
        check("model_blt_imm", pin.imm, 32'hFFFFFFF8);
        pin = model(I_ILL, 32'h0);
        check("model_ill_flag", 32'(pin.illegal), 32'd1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_imm", out_imm, 32'd0);
        #1 rst = 1'b0; out_ready = 1'b1;

        issue(I_ADD, 32'h100);
        @(negedge clk);
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_aluop", 32'(out_aluop), 32'd0);
        check("add_rs1", 32'(out_rs1), 32'd1);
        check("add_rs2", 32'(out_rs2), 32'd2);
        check("add_rd", 32'(out_rd), 32'd3);
        check("add_src2_imm", 32'(out_src2_imm), 32'd0);
        check("add_reg_write", 32'(out_reg_write), 32'd1);
        #1;
        issue(I_SRAI, 32'h104);
        @(negedge clk);
        check("srai_aluop", 32'(out_aluop), 32'd4);
        check("srai_rs1", 32'(out_rs1), 32'd6);
        check("srai_rd", 32'(out_rd), 32'd5);
        check("srai_imm", out_imm, 32'h00000003);
        check("srai_src2_imm", 32'(out_src2_imm), 32'd1);
        #1;
        issue(I_BLT, 32'h108);
        @(negedge clk);
        check("blt_aluop", 32'(out_aluop), 32'd8);
        check("blt_branch", 32'(out_branch), 32'd1);
        check("blt_funct3", 32'(out_funct3), 32'b100);
        check("blt_imm", out_imm, 32'hFFFFFFF8);
        check("blt_reg_write", 32'(out_reg_write), 32'd0);
        #1;

        for (int k = 0; k < 18; k++) issue(stream[k], 32'h200 + 32'(4 * k));
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: hold a bundle for three cycles while the next one waits.
        issue(I_ADD, 32'h300);
        out_ready = 1'b0;
        in_instr  = I_SUB;
        in_pc     = 32'h304;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold_pc", out_pc, 32'h300);
            check("bp_hold_rd", 32'(out_rd), 32'd3);
        end
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_refill_valid", 32'(out_valid), 32'd1);
        check("bp_refill_pc", out_pc, 32'h304);
        #1;
        for (int k = 0; k < 3; k++) begin
            issue(stream[k + 1], 32'h308 + 32'(4 * k));
            @(negedge clk);
            check("b2b_valid", 32'(out_valid), 32'd1);
            check("b2b_pc", out_pc, 32'h308 + 32'(4 * k));
            #1;
        end

        // Flush with a same-cycle offer: the offered instruction must be dropped.
        flush = 1'b1;
        issue(32'h123453B7, 32'h500);
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        #1;

        // Flush of a stalled bundle.
        issue(I_SRAI, 32'h600);
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("stall_valid", 32'(out_valid), 32'd1);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("stall_flush_valid", 32'(out_valid), 32'd0);
        #1 out_ready = 1'b1;

        // Illegal encoding, then reset while it is stalled.
        issue(I_ILL, 32'h700);
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("ill_flag", 32'(out_illegal), 32'd1);
        check("ill_aluop", 32'(out_aluop), 32'd0);
        check("ill_reg_write", 32'(out_reg_write), 32'd0);
        @(negedge clk);
        check("ill_held", 32'(out_illegal), 32'd1);
        #1 rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_pc", out_pc, 32'd0);
        check("midrst_out_illegal", 32'(out_illegal), 32'd0);
        check("midrst_out_rd", 32'(out_rd), 32'd0);
        #1 rst = 1'b0; out_ready = 1'b1;

        issue(32'h010000EF, 32'h800);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        hits = 0;
        foreach (delivered[k]) if (delivered[k] == 32'h500) hits++;
        check("flushed_never_delivered", 32'(hits), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Pipelined RV32I instruction decoder that turns a fetched 32-bit instruction into the 4-bit ALU operation code and operand controls consumed by the execute-stage ALU. It is one registered pipeline stage with valid/ready handshakes on both sides and a synchronous flush for branch redirects. It sits between the fetch unit and the execute stage.

## Interface
- DATA_WIDTH, 32, instruction, PC and immediate width (RV32I only; other values unsupported)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard held and incoming instruction (branch redirect)
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  stage can accept this cycle
- in_instr  in  32  raw instruction word
- in_pc  in  DATA_WIDTH  PC of in_instr
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute stage accepts bundle
- out_pc  out  DATA_WIDTH  registered PC
- out_aluop  out  4  ALU op code (encoding below)
- out_rs1, out_rs2, out_rd  out  5 each  register indices
- out_imm  out  DATA_WIDTH  decoded immediate
- out_src1_pc  out  1  ALU input0 = PC instead of rs1
- out_src2_imm  out  1  ALU input1 = imm instead of rs2
- out_reg_write  out  1  writes rd (0 when rd = x0)
- out_branch  out  1  conditional branch; out_funct3 qualifies it
- out_funct3  out  3  raw funct3 (branch/load/store width)
- out_illegal  out  1  unrecognised encoding

## Operation
- ALU op encoding: 0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 SRA, 5 AND, 6 OR, 7 XOR, 8 SLT, 9 SLTU.
- OP (0110011): funct3/funct7 → ADD/SUB (funct7[5]), SLL, SLT, SLTU, XOR, SRL/SRA (funct7[5]), OR, AND; src2_imm=0. funct7 not in {0x00, 0x20}, or 0x20 with funct3 not in {000, 101} → illegal.
- OP-IMM (0010011): same mapping, never SUB; src2_imm=1. Shifts: imm = {27'b0, shamt}, SRAI when funct7 = 0x20. Other shift funct7 values → illegal.
- LUI: aluop ADD, rs1 forced 0, imm = U-imm. AUIPC: ADD, src1_pc=1, U-imm.
- LOAD/STORE: ADD, src2_imm=1, I-/S-imm; STORE reg_write=0.
- BRANCH: branch=1, reg_write=0, imm = B-imm. BEQ/BNE → SUB; BLT/BGE → SLT; BLTU/BGEU → SLTU. funct3 010/011 → illegal.
- JAL: ADD, src1_pc=1, imm = J-imm. JALR: ADD, src2_imm=1, I-imm. Both reg_write=1.
- Immediates are sign-extended from instruction bit 31, except shamt.
- Illegal: out_illegal=1, aluop=0, reg_write=0, branch=0; bundle still flows so execute can trap.

## Timing
- Latency 1 cycle: accepted instruction appears on out_* on the next edge.
- in_ready = !rst && (!out_valid || out_ready), combinational. Transfer when valid && ready on either side.
- While out_valid && !out_ready, all out_* hold stable.
- Same-cycle out drain and in accept: new bundle loads, out_valid stays 1 (full throughput, no bubble).
- flush: next edge out_valid=0; an instruction accepted that cycle is dropped. flush wins over load.
- Reset: all outputs 0, out_valid=0. rst mid-stall discards held bundle.
- out_valid falls only on drain without refill, flush or rst.

## Structure
- Shared package decode_pkg: aluop enum (values above), opcode constants, funct3/funct7 constants; the execute ALU imports the same enum.
- One sub-module: imm_gen (combinational I/S/B/U/J/shamt immediate extraction).
- Decode logic is combinational ahead of one output register bank plus valid flag.

## Test plan
- 0x002081B3 (ADD x3,x1,x2) valid, out_ready=1 → next cycle aluop=0, rs1=1, rs2=2, rd=3, src2_imm=0, reg_write=1.
- 0x40335293 (SRAI x5,x6,3) → aluop=4, rs1=6, rd=5, imm=0x00000003, src2_imm=1.
- BLT x1,x2,-8 (0xFE20CCE3) → aluop=8, branch=1, funct3=100, imm=0xFFFFFFF8, reg_write=0.
- Backpressure: out_ready=0 for 3 cycles with bundle held → in_ready=0, outputs unchanged; out_ready=1 → back-to-back stream with no bubble.
- flush with in_valid=1 same cycle → out_valid=0 next cycle, instruction never appears.
- 0xFFFFFFFF → illegal=1, aluop=0, reg_write=0; rst asserted mid-stall → out_valid=0, all outputs 0.
